// File: rtl/add32.sv
// add32: registered carry-lookahead adder with carry, signed-overflow and zero flags.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every output and wins over in_valid
//   in_valid   in1/in2 hold operands this cycle
//   in1, in2   WIDTH-bit operands
//   out_valid  Out and the flags carry a fresh result (one cycle after in_valid)
//   Out        registered sum, in1 + in2 mod 2^WIDTH
//   carry_out  unsigned carry out of the MSB
//   overflow   signed overflow: equal operand signs, different sum sign
//   zero       registered sum equals 0

module add32_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_gg,
    output logic       o_gp
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // All in-group carries come straight from g/p and the group carry-in.
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_s  = w_p ^ w_c;
    assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_gp = &w_p;
endmodule

module add32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] Out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NG = WIDTH / 4;

    if (WIDTH % 4 != 0) begin : g_bad_width
        $error("add32: WIDTH must be a multiple of 4");
    end

    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;

    // Second-level lookahead: each group carry is a flat sum-of-products of
    // the group generate/propagate terms, so no carry ripples between groups.
    function automatic logic [NG:0] lookahead(input logic [NG-1:0] gg,
                                              input logic [NG-1:0] gp,
                                              input logic          ci);
        logic [NG:0] c;
        logic        term;
        c[0] = ci;
        for (int k = 1; k <= NG; k++) begin
            term = ci;
            for (int m = 0; m < k; m++) term = term & gp[m];
            c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) term = term & gp[m];
                c[k] = c[k] | term;
            end
        end
        return c;
    endfunction

    for (genvar g = 0; g < NG; g++) begin : g_grp
        add32_cla4 u_cla (
            .i_a  (in1[4*g +: 4]),
            .i_b  (in2[4*g +: 4]),
            .i_ci (w_c[g]),
            .o_s  (w_sum[4*g +: 4]),
            .o_gg (w_gg[g]),
            .o_gp (w_gp[g])
        );
    end

    assign w_c   = lookahead(w_gg, w_gp, 1'b0);
    assign w_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);

    // Result and flags only load on valid input; out_valid tracks in_valid every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_c[NG];
                r_ovf   <= w_ovf;
                r_zero  <= (w_sum == '0);
            end
        end
    end

    assign out_valid = r_valid;
    assign Out       = r_sum;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_add32.sv
// tb_add32: directed and random checks of add32 against hand-computed and 33-bit model results.
module tb_add32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic [31:0] Out;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;

    add32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .Out       (Out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Packed view {valid, carry, overflow, zero, sum}.
    function automatic logic [35:0] obs();
        return {out_valid, carry_out, overflow, zero, Out};
    endfunction

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got v/c/o/z/sum=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b};
        ov = (a[31] == b[31]) && (s[31] != a[31]);
        return {1'b1, s[32], ov, (s[31:0] == 32'd0), s[31:0]};
    endfunction

    logic [31:0] stress_a [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h0000FFFF, 32'h0FFFFFFF, 32'h7FFFFFFF};
    logic [31:0] stress_b [6] = '{32'h00000003, 32'h80000000, 32'hFFFFFFFF,
                                 32'h00000001, 32'h00000001, 32'h7FFFFFFF};

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        apply(1'b1, $urandom, $urandom);
        chk("reset0", obs(), 36'h0);
        apply(1'b1, $urandom, $urandom);
        chk("reset1", obs(), 36'h0);
        rst = 1'b0;

        apply(1'b1, 32'hFFFFFFFF, 32'd1);
        chk("wrap_to_zero", obs(), {4'b1101, 32'h0});
        apply(1'b1, 32'hFFFFFFFF, 32'd2);
        chk("wrap_to_one", obs(), {4'b1100, 32'h1});

        apply(1'b1, 32'd555, 32'd246);
        chk("b2b_801", obs(), {4'b1000, 32'd801});
        apply(1'b1, 32'd0, 32'd12345678);
        chk("b2b_12345678", obs(), {4'b1000, 32'd12345678});
        apply(1'b1, 32'd6, 32'd9);
        chk("b2b_15", obs(), {4'b1000, 32'd15});

        apply(1'b0, 32'd99, 32'd100);
        chk("idle_hold", obs(), {4'b0000, 32'd15});

        rst = 1'b1;
        apply(1'b1, 32'd3, 32'd4);
        chk("rst_priority", obs(), 36'h0);
        rst = 1'b0;
        apply(1'b1, 32'd3, 32'd4);
        chk("after_rst", obs(), {4'b1000, 32'd7});

        apply(1'b1, 32'h7FFFFFFF, 32'd1);
        chk("ovf_pos", obs(), {4'b1010, 32'h80000000});
        apply(1'b1, 32'h80000000, 32'h80000000);
        chk("ovf_neg", obs(), {4'b1111, 32'h0});

        for (int i = 0; i < 6; i++) begin
            apply(1'b1, stress_a[i], stress_b[i]);
            chk($sformatf("stress%0d", i), obs(), model(stress_a[i], stress_b[i]));
        end

        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            b = (i % 7 == 0) ? ~a + 32'($urandom_range(0, 2)) : $urandom;
            apply(1'b1, a, b);
            chk("random", obs(), model(a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
